router_fsm: RTL and testbench

//  Ingress control FSM of the 1x3 router.
//  - Sits between the source port and the register/synchronizer/FIFO stages.
//  - Decodes the destination from the header byte and sequences header, payload and parity loading.
//  - Generates the lfd_state and write strobes consumed by the per-port FIFOs.
//  - Stalls the source on FIFO-full and on a non-empty target FIFO.
//  - Packet format:
//    - header: [7:2] payload length, [1:0] destination address.
//    - Then the payload bytes, then one parity byte.
//    - pkt_valid is high from header through last payload byte, low at the parity byte.

---
 rtl/router_pkg.sv | 34 +++
 rtl/router_fsm.sv | 91 +++++++++
 tb/tb_router_fsm.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router ingress control: port count, header
// address width and the ingress FSM state encoding.
package router_pkg;

  localparam int NUM_PORTS = 3;
  localparam int ADDR_W    = 2;
  localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'b11;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_t;

  function automatic logic addr_valid(input logic [ADDR_W-1:0] a);
    return (a != INVALID_ADDR) && (int'(a) < NUM_PORTS);
  endfunction

  // Per-port flag lookup; an out-of-range address reads as 0.
  function automatic logic port_bit(input logic [NUM_PORTS-1:0] v,
                                    input logic [ADDR_W-1:0]    a);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (int'(a) == i) r = v[i];
    return r;
  endfunction

endpackage

// File: rtl/router_fsm.sv
// Ingress control FSM of the 1x3 router: decodes the header address and
// sequences header, payload and parity loads into the per-port FIFOs.
//
// state              | meaning
// DECODE_ADDRESS     | idle, waiting for a header byte
// LOAD_FIRST_DATA    | header byte written to target FIFO
// LOAD_DATA          | payload bytes streaming
// FIFO_FULL_STATE    | target FIFO full, source stalled
// LOAD_AFTER_FULL    | write the byte held during the stall
// LOAD_PARITY        | parity byte written
// CHECK_PARITY_ERROR | parity compare, internal registers cleared
// WAIT_TILL_EMPTY    | target FIFO still draining previous packet
module router_fsm
  import router_pkg::*;
(
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 pkt_valid,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  input  logic                 parity_done,
  input  logic                 low_pkt_valid,
  output logic                 busy,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 laf_state,
  output logic                 full_state,
  output logic                 write_enb_reg,
  output logic                 rst_int_reg
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= DECODE_ADDRESS;
      addr_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == DECODE_ADDRESS && pkt_valid)
        addr_q <= data_in;
    end
  end

  always_comb begin
    state_nxt = state;
    // A timeout on the packet's own FIFO aborts the packet from any busy state.
    if (state != DECODE_ADDRESS && port_bit(soft_reset, addr_q)) begin
      state_nxt = DECODE_ADDRESS;
    end else begin
      case (state)
        DECODE_ADDRESS:
          if (pkt_valid && addr_valid(data_in))
            state_nxt = port_bit(fifo_empty, data_in) ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        LOAD_FIRST_DATA:
          state_nxt = LOAD_DATA;
        LOAD_DATA:
          if (fifo_full)       state_nxt = FIFO_FULL_STATE;
          else if (!pkt_valid) state_nxt = LOAD_PARITY;
        FIFO_FULL_STATE:
          if (!fifo_full) state_nxt = LOAD_AFTER_FULL;
        LOAD_AFTER_FULL:
          if (parity_done)        state_nxt = DECODE_ADDRESS;
          else if (low_pkt_valid) state_nxt = LOAD_PARITY;
          else                    state_nxt = LOAD_DATA;
        LOAD_PARITY:
          state_nxt = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR:
          state_nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        WAIT_TILL_EMPTY:
          if (port_bit(fifo_empty, addr_q)) state_nxt = LOAD_FIRST_DATA;
        default:
          state_nxt = DECODE_ADDRESS;
      endcase
    end
  end

  assign detect_add    = (state == DECODE_ADDRESS);
  assign lfd_state     = (state == LOAD_FIRST_DATA);
  assign ld_state      = (state == LOAD_DATA);
  assign laf_state     = (state == LOAD_AFTER_FULL);
  assign full_state    = (state == FIFO_FULL_STATE);
  assign rst_int_reg   = (state == CHECK_PARITY_ERROR);
  assign busy          = !(detect_add || ld_state);
  assign write_enb_reg = ld_state || laf_state || (state == LOAD_PARITY);

endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: fixed vector table, directed corner
// sequences and a randomized run against a packet-level reference model.
module tb_router_fsm;

  logic       clock = 1'b0;
  logic       resetn, pkt_valid, fifo_full, parity_done, low_pkt_valid;
  logic [1:0] data_in;
  logic [2:0] fifo_empty, soft_reset;
  logic       busy, detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg;
  logic [7:0] dut_out;

  router_fsm dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .busy(busy), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .write_enb_reg(write_enb_reg), .rst_int_reg(rst_int_reg)
  );

  always #5 clock = ~clock;

  assign dut_out = {busy, detect_add, lfd_state, ld_state,
                    laf_state, full_state, write_enb_reg, rst_int_reg};

  // {busy, detect_add, lfd, ld, laf, full, write_enb, rst_int}
  localparam logic [7:0] O_DA  = 8'b0100_0000;
  localparam logic [7:0] O_LFD = 8'b1010_0000;
  localparam logic [7:0] O_LD  = 8'b0001_0010;
  localparam logic [7:0] O_FFS = 8'b1000_0100;
  localparam logic [7:0] O_LAF = 8'b1000_1010;
  localparam logic [7:0] O_LP  = 8'b1000_0010;
  localparam logic [7:0] O_CPE = 8'b1000_0001;
  localparam logic [7:0] O_WTE = 8'b1000_0000;

  typedef enum int {PH_IDLE, PH_HDR, PH_BODY, PH_STALL, PH_RESUME,
                    PH_PAR, PH_CHK, PH_WAIT} ph_t;
  ph_t m_ph;
  int  m_addr;
  int  n_vec, n_err;

  typedef struct {
    logic       pv;
    logic [1:0] din;
    logic       full;
    logic [2:0] empty;
    logic [2:0] sr;
    logic       pd;
    logic       lpv;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[12];

  function automatic logic [7:0] ph_out(input ph_t p);
    case (p)
      PH_HDR:    return O_LFD;
      PH_BODY:   return O_LD;
      PH_STALL:  return O_FFS;
      PH_RESUME: return O_LAF;
      PH_PAR:    return O_LP;
      PH_CHK:    return O_CPE;
      PH_WAIT:   return O_WTE;
      default:   return O_DA;
    endcase
  endfunction

  task automatic drv(input logic pv, input logic [1:0] din, input logic full,
                     input logic [2:0] empty, input logic [2:0] sr,
                     input logic pd, input logic lpv);
    pkt_valid = pv; data_in = din; fifo_full = full; fifo_empty = empty;
    soft_reset = sr; parity_done = pd; low_pkt_valid = lpv;
  endtask

  // One clock edge; the reference model advances on the same edge.
  task automatic step();
    ph_t nx;
    @(posedge clock);
    nx = m_ph;
    if (!resetn) begin
      nx = PH_IDLE;
      m_addr = 0;
    end else if (m_ph != PH_IDLE && soft_reset[m_addr]) begin
      nx = PH_IDLE;
    end else begin
      case (m_ph)
        PH_IDLE: if (pkt_valid) begin
          m_addr = int'(data_in);
          if (m_addr < 3) nx = fifo_empty[m_addr] ? PH_HDR : PH_WAIT;
        end
        PH_HDR:    nx = PH_BODY;
        PH_BODY:   nx = fifo_full ? PH_STALL : (!pkt_valid ? PH_PAR : PH_BODY);
        PH_STALL:  nx = fifo_full ? PH_STALL : PH_RESUME;
        PH_RESUME: nx = parity_done ? PH_IDLE : (low_pkt_valid ? PH_PAR : PH_BODY);
        PH_PAR:    nx = PH_CHK;
        PH_CHK:    nx = fifo_full ? PH_STALL : PH_IDLE;
        PH_WAIT:   nx = fifo_empty[m_addr] ? PH_HDR : PH_WAIT;
        default:   nx = PH_IDLE;
      endcase
    end
    m_ph = nx;
    @(negedge clock);
  endtask

  task automatic chk(input string nm, input logic [7:0] exp);
    n_vec++;
    if (dut_out !== exp) begin
      n_err++;
      $display("FAIL %s: outputs %b, expected %b", nm, dut_out, exp);
    end
  endtask

  task automatic idle_in();
    drv(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    m_ph = PH_IDLE; m_addr = 0;
    resetn = 1'b0;
    idle_in();

    tbl[0]  = '{1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LFD};
    tbl[1]  = '{1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LD};
    tbl[2]  = '{1'b1, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LD};
    tbl[3]  = '{1'b1, 2'd3, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LD};
    tbl[4]  = '{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LP};
    tbl[5]  = '{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_CPE};
    tbl[6]  = '{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_DA};
    tbl[7]  = '{1'b1, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LFD};
    tbl[8]  = '{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LD};
    tbl[9]  = '{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LP};
    tbl[10] = '{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_CPE};
    tbl[11] = '{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_DA};

    @(negedge clock);
    chk("reset", O_DA);
    resetn = 1'b1;

    // Nominal 3-byte packet to port 1, then zero-length packet to port 2.
    for (int i = 0; i < 12; i++) begin
      drv(tbl[i].pv, tbl[i].din, tbl[i].full, tbl[i].empty,
          tbl[i].sr, tbl[i].pd, tbl[i].lpv);
      step();
      chk($sformatf("tbl%0d", i), tbl[i].exp);
    end

    // Target FIFO 2 still draining.
    drv(1'b1, 2'd2, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("wait%0d", i), O_WTE);
    end
    fifo_empty = 3'b111;
    step(); chk("wait_lfd", O_LFD);
    pkt_valid = 1'b0;
    step(); chk("wait_ld", O_LD);
    step(); chk("wait_lp", O_LP);
    step(); chk("wait_cpe", O_CPE);
    step(); chk("wait_da", O_DA);

    // Full stall: resume, low_pkt_valid exit, CHECK_PARITY full, parity_done exit.
    drv(1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    step(); chk("full_lfd", O_LFD);
    step(); chk("full_ld", O_LD);
    fifo_full = 1'b1;
    step(); chk("full_ffs0", O_FFS);
    step(); chk("full_ffs1", O_FFS);
    fifo_full = 1'b0;
    step(); chk("full_laf", O_LAF);
    step(); chk("full_ld2", O_LD);
    fifo_full = 1'b1;
    step(); chk("full_ffs2", O_FFS);
    fifo_full = 1'b0;
    step(); chk("full_laf2", O_LAF);
    low_pkt_valid = 1'b1; pkt_valid = 1'b0;
    step(); chk("lpv_lp", O_LP);
    low_pkt_valid = 1'b0;
    step(); chk("lpv_cpe", O_CPE);
    fifo_full = 1'b1;
    step(); chk("cpe_ffs", O_FFS);
    fifo_full = 1'b0;
    step(); chk("cpe_laf", O_LAF);
    parity_done = 1'b1;
    step(); chk("pd_da", O_DA);
    idle_in();

    // Soft reset: only the addressed port's timeout aborts.
    drv(1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    step(); chk("sr_lfd", O_LFD);
    step(); chk("sr_ld", O_LD);
    soft_reset = 3'b010;
    step(); chk("sr_other", O_LD);
    soft_reset = 3'b001;
    step(); chk("sr_abort", O_DA);
    idle_in();

    // Address 3 is ignored.
    drv(1'b1, 2'd3, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("inv%0d", i), O_DA);
    end

    // Asynchronous reset in the middle of a payload.
    drv(1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    step(); chk("rst_lfd", O_LFD);
    step(); chk("rst_ld", O_LD);
    resetn = 1'b0;
    #1;
    chk("rst_async", O_DA);
    m_ph = PH_IDLE; m_addr = 0;
    @(negedge clock);
    chk("rst_hold", O_DA);
    resetn = 1'b1;
    idle_in();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      pkt_valid     = ($urandom_range(0, 3) != 0);
      data_in       = 2'($urandom_range(0, 3));
      fifo_full     = ($urandom_range(0, 3) == 0);
      fifo_empty    = 3'($urandom_range(0, 7));
      soft_reset    = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      parity_done   = ($urandom_range(0, 5) == 0);
      low_pkt_valid = ($urandom_range(0, 5) == 0);
      resetn        = ($urandom_range(0, 99) != 0);
      step();
      chk($sformatf("rand%0d", i), ph_out(m_ph));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
